// File: rtl/evo_pmux_arb.sv
// Round-robin owner arbiter for one Evo port's dir/out/en pin-mux triplet,
// with a one-cycle quiet turnaround between owners and optional hold-timeout preemption.
//   state | meaning
//   IDLE  | no owner, pins quiet, pick next requester from pointer
//   GRANT | owner drives pins, hold counter runs on en1mhz
//   DRAIN | one quiet cycle, pointer moves past the old owner
module evo_pmux_arb #(
    parameter int NUM_REQ = 4,
    parameter int PWIDTH  = 8,
    parameter int TMO_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en1mhz,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*PWIDTH-1:0] req_dir_i,
    input  logic [NUM_REQ*PWIDTH-1:0] req_out_i,
    input  logic [NUM_REQ*PWIDTH-1:0] req_en_i,
    input  logic [TMO_W-1:0]          timeout_i,
    input  logic                      lock_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      busy_o,
    output logic                      preempt_o,
    output logic [PWIDTH-1:0]         pmux_dir_o,
    output logic [PWIDTH-1:0]         pmux_out_o,
    output logic [PWIDTH-1:0]         pmux_en_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_DRAIN} state_t;

    state_t             r_state;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_owner;
    logic [TMO_W-1:0]   r_cnt;

    logic [IW-1:0]      w_sel;
    logic               w_found;
    logic [IW-1:0]      w_ptr_next;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic [NUM_REQ-1:0] w_sel_oh;
    logic               w_release;
    logic               w_others;
    logic               w_preempt;
    logic [PWIDTH-1:0]  w_dir;
    logic [PWIDTH-1:0]  w_out;
    logic [PWIDTH-1:0]  w_en;

    // First set request at or above the pointer, wrapping around.
    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req_i[(int'(r_ptr) + i) % NUM_REQ]) begin
                w_found = 1'b1;
                w_sel   = IW'((int'(r_ptr) + i) % NUM_REQ);
            end
        end
    end

    assign w_owner_oh = ONE << r_owner;
    assign w_sel_oh   = ONE << w_sel;
    assign w_ptr_next = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
    assign w_release  = ~req_i[r_owner];
    assign w_others   = |(req_i & ~w_owner_oh);
    assign w_preempt  = (timeout_i != '0) && (r_cnt >= timeout_i) && !lock_i && w_others;

    assign w_dir = req_dir_i[int'(r_owner)*PWIDTH +: PWIDTH];
    assign w_out = req_out_i[int'(r_owner)*PWIDTH +: PWIDTH];
    assign w_en  = req_en_i[int'(r_owner)*PWIDTH +: PWIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_cnt      <= '0;
            grant_o    <= '0;
            busy_o     <= 1'b0;
            preempt_o  <= 1'b0;
            pmux_dir_o <= '0;
            pmux_out_o <= '0;
            pmux_en_o  <= '0;
        end else begin
            preempt_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    pmux_dir_o <= '0;
                    pmux_out_o <= '0;
                    pmux_en_o  <= '0;
                    if (w_found) begin
                        r_owner <= w_sel;
                        r_cnt   <= '0;
                        grant_o <= w_sel_oh;
                        busy_o  <= 1'b1;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    pmux_dir_o <= w_dir;
                    pmux_out_o <= w_out;
                    pmux_en_o  <= w_en;
                    if (en1mhz && (r_cnt != '1)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    // A voluntary release wins over a coincident timeout.
                    if (w_release || w_preempt) begin
                        grant_o   <= '0;
                        busy_o    <= 1'b0;
                        preempt_o <= ~w_release;
                        r_state   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    pmux_dir_o <= '0;
                    pmux_out_o <= '0;
                    pmux_en_o  <= '0;
                    grant_o    <= '0;
                    busy_o     <= 1'b0;
                    r_ptr      <= w_ptr_next;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_evo_pmux_arb.sv
// Directed bench for evo_pmux_arb: single owner, round-robin, preemption, lock,
// release/timeout tie, disabled timeout with counter saturation, reset mid-grant.
module tb_evo_pmux_arb;

    localparam int NR = 4;
    localparam int PW = 8;
    localparam int TW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              en1mhz;
    logic [NR-1:0]     req_i;
    logic [NR*PW-1:0]  req_dir_i;
    logic [NR*PW-1:0]  req_out_i;
    logic [NR*PW-1:0]  req_en_i;
    logic [TW-1:0]     timeout_i;
    logic              lock_i;
    logic [NR-1:0]     grant_o;
    logic              busy_o;
    logic              preempt_o;
    logic [PW-1:0]     pmux_dir_o;
    logic [PW-1:0]     pmux_out_o;
    logic [PW-1:0]     pmux_en_o;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    evo_pmux_arb #(.NUM_REQ(NR), .PWIDTH(PW), .TMO_W(TW)) dut (
        .clk        (clk),
        .reset      (reset),
        .en1mhz     (en1mhz),
        .req_i      (req_i),
        .req_dir_i  (req_dir_i),
        .req_out_i  (req_out_i),
        .req_en_i   (req_en_i),
        .timeout_i  (timeout_i),
        .lock_i     (lock_i),
        .grant_o    (grant_o),
        .busy_o     (busy_o),
        .preempt_o  (preempt_o),
        .pmux_dir_o (pmux_dir_o),
        .pmux_out_o (pmux_out_o),
        .pmux_en_o  (pmux_en_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1);
    end

    initial begin
        logic seen;
        int   order [5] = '{0, 1, 2, 3, 0};
        int   w;

        reset     = 1'b1;
        en1mhz    = 1'b0;
        req_i     = '0;
        timeout_i = '0;
        lock_i    = 1'b0;
        for (int k = 0; k < NR; k++) begin
            req_dir_i[k*PW +: PW] = 8'(8'h10 + k);
            req_out_i[k*PW +: PW] = 8'(8'h20 + k);
            req_en_i[k*PW +: PW]  = (k == 0) ? 8'hFF : 8'(8'hE0 + k);
        end
        step();
        step();
        chk("rst_grant", grant_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_preempt", preempt_o, 0);
        chk("rst_pmux_en", pmux_en_o, 0);
        reset = 1'b0;

        // Single requester
        req_i = 4'b0001;
        step();
        chk("s_grant", grant_o, 4'b0001);
        chk("s_busy", busy_o, 1);
        chk("s_en_lag", pmux_en_o, 8'h00);
        step();
        chk("s_en", pmux_en_o, 8'hFF);
        chk("s_dir", pmux_dir_o, 8'h10);
        chk("s_out", pmux_out_o, 8'h20);
        req_en_i[0 +: PW] = 8'h5A;
        step();
        chk("s_follow", pmux_en_o, 8'h5A);
        req_i = 4'b0000;
        step();
        chk("s_rel_grant", grant_o, 0);
        chk("s_rel_busy", busy_o, 0);
        chk("s_rel_en1", pmux_en_o, 8'h5A);
        step();
        chk("s_rel_en2", pmux_en_o, 8'h00);

        // Round-robin from a fresh pointer
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_i = 4'b1111;
        foreach (order[j]) begin
            w = 0;
            while (grant_o == 0 && w < 8) begin
                step();
                w++;
            end
            chk("rr_grant", grant_o, 32'(1) << order[j]);
            step();
            chk("rr_dir", pmux_dir_o, 32'h10 + order[j]);
            step();
            req_i[order[j]] = 1'b0;
            step();
            chk("rr_drain_grant", grant_o, 0);
            step();
            chk("rr_drain_dir", pmux_dir_o, 0);
            chk("rr_drain_en", pmux_en_o, 0);
            req_i[order[j]] = 1'b1;
        end
        req_i = 4'b0000;
        step();
        step();

        // Preemption: pointer is 1, so owner 0 must request alone first
        timeout_i = 4'd5;
        req_i = 4'b0001;
        step();
        chk("pre_own0", grant_o, 4'b0001);
        req_i = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            en1mhz = 1'b1;
            step();
            en1mhz = 1'b0;
            if (i < 4) step();
        end
        chk("pre_hold", grant_o, 4'b0001);
        chk("pre_early", preempt_o, 0);
        step();
        chk("pre_pulse", preempt_o, 1);
        chk("pre_grant0", grant_o, 0);
        step();
        chk("pre_once", preempt_o, 0);
        chk("pre_quiet", pmux_dir_o, 0);
        step();
        chk("pre_newown", grant_o, 4'b0100);

        // Lock inhibits preemption but the counter keeps running
        lock_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            en1mhz = 1'b1;
            step();
            seen |= preempt_o;
            en1mhz = 1'b0;
            step();
            seen |= preempt_o;
        end
        chk("lock_nopre", seen, 0);
        chk("lock_hold", grant_o, 4'b0100);
        lock_i = 1'b0;
        step();
        chk("unlock_pre", preempt_o, 1);
        step();
        step();
        chk("unlock_newown", grant_o, 4'b0001);

        // Release coincides with timeout: counts as release
        for (int i = 0; i < 5; i++) begin
            en1mhz = 1'b1;
            step();
            en1mhz = 1'b0;
            if (i < 4) step();
        end
        req_i = 4'b0100;
        step();
        chk("tie_nopre", preempt_o, 0);
        chk("tie_drain", grant_o, 0);
        step();
        chk("tie_nopre2", preempt_o, 0);
        chk("tie_quiet", pmux_en_o, 0);
        step();
        chk("tie_newown", grant_o, 4'b0100);

        // Timeout disabled for 100 ticks; counter must saturate, not wrap
        timeout_i = 4'd0;
        req_i = 4'b0101;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            en1mhz = 1'b1;
            step();
            seen |= preempt_o;
            en1mhz = 1'b0;
            step();
            seen |= preempt_o;
        end
        chk("tmo0_nopre", seen, 0);
        chk("tmo0_hold", grant_o, 4'b0100);
        timeout_i = 4'd15;
        step();
        chk("sat_pre", preempt_o, 1);
        timeout_i = 4'd0;
        step();
        req_i = 4'b1000;
        step();
        chk("own3", grant_o, 4'b1000);
        step();
        chk("own3_dir", pmux_dir_o, 8'h13);

        // Reset while owner 3 holds the pins
        reset = 1'b1;
        step();
        chk("mrst_grant", grant_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_dir", pmux_dir_o, 0);
        chk("mrst_out", pmux_out_o, 0);
        chk("mrst_en", pmux_en_o, 0);
        reset = 1'b0;
        req_i = 4'b1010;
        step();
        chk("mrst_ptr0", grant_o, 4'b0010);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/evo_pmux_arb.md
# evo_pmux_arb

Round-robin ownership arbiter for one Evo port's pin-mux triplets (dir/out/en). It sits between several XB/IP requesters and one port input of the XB pin mux. It grants exclusive control of the port pins to one requester at a time and inserts a one-cycle quiet turnaround between owners. An optional microsecond hold timeout lets waiting requesters preempt a long-running owner.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- PWIDTH, 8, port pin width
- TMO_W, 16, timeout counter width

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- en1mhz  in  1  single-cycle 1 MHz tick enable
- req_i  in  NUM_REQ  level request per requester; held for the duration of ownership
- req_dir_i  in  NUM_REQ*PWIDTH  per-requester dir triplet slice; requester k at [k*PWIDTH +: PWIDTH]
- req_out_i  in  NUM_REQ*PWIDTH  per-requester out slice, same packing
- req_en_i  in  NUM_REQ*PWIDTH  per-requester en slice, same packing
- timeout_i  in  TMO_W  hold limit in en1mhz ticks; 0 disables preemption
- lock_i  in  1  when high, preemption is inhibited
- grant_o  out  NUM_REQ  one-hot current owner; 0 when no owner
- busy_o  out  1  state is GRANT
- preempt_o  out  1  one-cycle pulse when an owner is forcibly revoked
- pmux_dir_o, pmux_out_o, pmux_en_o  out  PWIDTH each  registered triplet to the pin mux

## Operation
- Three states: IDLE, GRANT, DRAIN. Reset enters IDLE.
- Reset values: pointer = 0, owner = 0, counter = 0. All outputs are 0.
- IDLE:
  - If req_i != 0, select the first set bit searching upward from the pointer, wrapping modulo NUM_REQ.
  - Load owner, clear the counter, and go to GRANT.
  - If req_i = 0, stay in IDLE.
- GRANT:
  - grant_o = onehot(owner).
  - Output registers load the owner's slices every cycle.
  - Counter increments on en1mhz and saturates at all-ones.
  - Release: if req_i[owner] = 0, go to DRAIN.
  - Preempt: if timeout_i != 0, counter >= timeout_i, lock_i = 0, and any other req_i bit is set, go to DRAIN and pulse preempt_o on the next cycle.
  - If release and preempt conditions are both true in the same cycle, it counts as a release; preempt_o is not pulsed.
- DRAIN (exactly 1 cycle):
  - grant_o = 0.
  - Output registers load 0.
  - pointer = owner+1, modulo NUM_REQ.
  - Go to IDLE.
- A requester that was preempted and keeps req_i high re-enters arbitration behind the others because of the pointer advance.
- Changes to lock_i or timeout_i take effect on the next cycle's compare. Raising lock_i does not clear the counter.
- Requester slices are never sampled unless that requester is the owner in GRANT.

## Timing
- req_i rises at edge N with the arbiter in IDLE:
  - grant_o valid and busy_o high after edge N+1.
  - Owner triplet on pmux_*_o after edge N+2.
- Owner drops req_i before edge M:
  - DRAIN after edge M; grant_o = 0.
  - pmux_*_o = 0 after edge M+1.
  - IDLE after edge M+1.
  - Next grant after edge M+2 at the earliest.
- Minimum gap between owners is one cycle of zero triplet output plus one IDLE cycle. Two different owners never drive the pins on adjacent cycles.
- preempt_o is high only for the cycle in DRAIN entered by preemption.
- Reset asserted mid-GRANT: at the next edge, all outputs are 0, state is IDLE, and the pointer is 0.
- Requester triplet changes during GRANT appear on pmux_*_o one cycle later.

## Test plan
- Single requester, NUM_REQ=4: req_i=0001 with req_en slice 0xFF.
  - grant_o=0001 one cycle later; pmux_en_o=0xFF two cycles later.
  - Drop req: pmux_en_o=0x00 two cycles after the drop.
- Round-robin: req_i=1111 held, each owner releasing and re-requesting after 3 cycles.
  - Grant order 0,1,2,3,0.
  - Every handover shows one DRAIN cycle with grant_o=0 and the triplet at 0.
- Preemption: timeout_i=5, owner 0 holds while req 2 waits.
  - After 5 en1mhz ticks, preempt_o pulses once and grant moves to 2.
  - Repeat with lock_i=1: no preempt_o and no grant change.
- Simultaneous release and timeout: owner drops req_i on the same cycle the counter reaches timeout_i.
  - DRAIN is entered; preempt_o stays 0.
- timeout_i=0: owner holds 100 µs with others requesting.
  - No preemption occurs.
  - The counter saturates without wrap, checked with TMO_W=4.
- Reset mid-grant: assert reset while owner 3 is granted.
  - Next cycle: grant_o=0 and pmux_*_o=0.
  - After reset with req_i=1010, owner 1 is granted first (pointer = 0).
